// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: NCO oversampling, 3-tick majority vote, valid/ready holding register,
// separate framing/parity/overrun pulses. Define UART_RX_BREAK_DET_EN to add the break_det output.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int NCO_WIDTH  = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 rdata_vld,
    input  logic                 rdata_rdy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                 break_det
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam longint INC_L = ((longint'(BAUD_RATE) * longint'(OVERSAMPLE) * (longint'(1) << NCO_WIDTH)) * 2
                                + longint'(CLK_FREQ)) / (longint'(CLK_FREQ) * 2);
    localparam logic [NCO_WIDTH:0] INC = INC_L[NCO_WIDTH:0];
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_RX_BREAK_DET_EN
    localparam bit BREAK_EN = 1'b1;
`else
    localparam bit BREAK_EN = 1'b0;
`endif

    state_t                 state_q, state_d;
    logic [NCO_WIDTH-1:0]   acc_q;
    logic [NCO_WIDTH:0]     acc_sum;
    logic                   tick;
    logic                   sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   s0_q, s1_q;
    logic [DATA_BITS-1:0]   shift_q, rdata_q;
    logic [3:0]             bit_cnt_q;
    logic                   stop_err_q, stop_one_q, par_err_q, par_bit_q, brk_wait_q;
    logic                   vld_q, frame_err_q, parity_err_q, overrun_err_q;
    logic                   start_det, sample_now, vote, exp_par, last_data, last_stop;
    logic                   done, stop_bad, is_break, word_ok;

    assign acc_sum    = {1'b0, acc_q} + INC;
    assign tick       = acc_sum[NCO_WIDTH];
    assign start_det  = (state_q == S_IDLE) && prev_q && !sync2_q;
    assign sample_now = tick && (cnt_q == CNT_HI);
    assign vote       = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
    assign exp_par    = (PARITY == 2) ? ~^shift_q : ^shift_q;
    assign last_data  = (bit_cnt_q == LAST_DATA);
    assign last_stop  = (bit_cnt_q == LAST_STOP);
    assign done       = (state_q == S_STOP) && !brk_wait_q && sample_now && last_stop;
    assign stop_bad   = stop_err_q | ~vote;
    // A break is an all-zero frame including every stop bit; it implies stop_bad.
    assign is_break   = BREAK_EN && (shift_q == '0) && !par_bit_q && !stop_one_q && !vote;
    assign word_ok    = !stop_bad && !par_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every path of a combinational block starts from a default so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_det) state_d = S_START;
            S_START:  if (sample_now) state_d = vote ? S_IDLE : S_DATA;
            S_DATA:   if (sample_now && last_data) state_d = (PARITY == 0) ? S_STOP : S_PARITY;
            S_PARITY: if (sample_now) state_d = S_STOP;
            S_STOP: begin
                if (brk_wait_q) begin
                    if (sync2_q) state_d = S_IDLE;
                end else if (done && !is_break) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: synchroniser and edge register reset to the idle level so reset release is not a start edge.
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            acc_q         <= '0;
            cnt_q         <= '0;
            s0_q          <= 1'b1;
            s1_q          <= 1'b1;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            stop_err_q    <= 1'b0;
            stop_one_q    <= 1'b0;
            par_err_q     <= 1'b0;
            par_bit_q     <= 1'b0;
            brk_wait_q    <= 1'b0;
            rdata_q       <= '0;
            vld_q         <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            acc_q   <= acc_sum[NCO_WIDTH-1:0];
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;

            if (start_det)  cnt_q <= '0;
            else if (tick)  cnt_q <= (cnt_q == CNT_WRAP) ? '0 : cnt_q + 1'b1;
            if (tick && cnt_q == CNT_LO)  s0_q <= sync2_q;
            if (tick && cnt_q == CNT_MID) s1_q <= sync2_q;

            if (sample_now) begin
                case (state_q)
                    S_START: begin
                        bit_cnt_q  <= '0;
                        stop_err_q <= 1'b0;
                        stop_one_q <= 1'b0;
                        par_err_q  <= 1'b0;
                        par_bit_q  <= 1'b0;
                    end
                    S_DATA: begin
                        shift_q   <= {vote, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= last_data ? '0 : bit_cnt_q + 1'b1;
                    end
                    S_PARITY: begin
                        par_err_q <= vote ^ exp_par;
                        par_bit_q <= vote;
                    end
                    S_STOP: begin
                        if (!brk_wait_q) begin
                            stop_err_q <= stop_err_q | ~vote;
                            stop_one_q <= stop_one_q | vote;
                            bit_cnt_q  <= last_stop ? '0 : bit_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (done && is_break) brk_wait_q <= 1'b1;
            else if (sync2_q)     brk_wait_q <= 1'b0;

            frame_err_q   <= done && stop_bad && !is_break;
            parity_err_q  <= done && !stop_bad && par_err_q;
            overrun_err_q <= done && word_ok && vld_q && !rdata_rdy;

            // Accepting the old word in the completion cycle frees the register for the new one.
            if (done && word_ok && (!vld_q || rdata_rdy)) begin
                rdata_q <= shift_q;
                vld_q   <= 1'b1;
            end else if (vld_q && rdata_rdy) begin
                vld_q   <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic break_q;
    always_ff @(posedge clk) begin
        if (rst) break_q <= 1'b0;
        else     break_q <= done && is_break;
    end
    assign break_det = break_q;
`endif

    assign rdata       = rdata_q;
    assign rdata_vld   = vld_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;

endmodule
